mem_copy_engine: RTL and testbench

//  Memory-side initiator for data_memory: copies LEN words from SRC to DST.

---
 rtl/mem_copy_pkg.sv | 16 +
 rtl/mem_copy_addr_gen.sv | 63 ++++++
 rtl/mem_copy_engine.sv | 141 ++++++++++++++
 tb/tb_mem_copy_engine.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_copy_pkg.sv
// Shared types and default widths for the memory copy engine.
package mem_copy_pkg;

  localparam int unsigned MC_ADDR_W    = 32;
  localparam int unsigned MC_DATA_W    = 32;
  localparam int unsigned MC_LEN_W     = 16;
  localparam int unsigned MC_MEM_DEPTH = 4000;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_WRITE,
    ST_DONE
  } mc_state_t;

endpackage

// File: rtl/mem_copy_addr_gen.sv
// Up/down word index counter for the copy engine; presents src+i and dst+i for the
// index that will be current after the next clock edge.
module mem_copy_addr_gen
  import mem_copy_pkg::*;
#(
  parameter int unsigned ADDR_W = MC_ADDR_W,
  parameter int unsigned LEN_W  = MC_LEN_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              step,
  input  logic              desc,
  input  logic [ADDR_W-1:0] src,
  input  logic [ADDR_W-1:0] dst,
  input  logic [LEN_W-1:0]  len,
  output logic [ADDR_W-1:0] src_addr,
  output logic [ADDR_W-1:0] dst_addr,
  output logic              last
);

  localparam logic [LEN_W-1:0] ONE = LEN_W'(1);

  logic [ADDR_W-1:0] src_q;
  logic [ADDR_W-1:0] dst_q;
  logic [LEN_W-1:0]  idx;
  logic [LEN_W-1:0]  idx_n;
  logic [LEN_W-1:0]  end_idx;
  logic              desc_q;

  always_comb begin
    idx_n = idx;
    if (load) begin
      idx_n = desc ? (len - ONE) : '0;
    end else if (step) begin
      idx_n = desc_q ? (idx - ONE) : (idx + ONE);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      src_q   <= '0;
      dst_q   <= '0;
      idx     <= '0;
      end_idx <= '0;
      desc_q  <= 1'b0;
    end else begin
      idx <= idx_n;
      if (load) begin
        src_q   <= src;
        dst_q   <= dst;
        desc_q  <= desc;
        end_idx <= desc ? '0 : (len - ONE);
      end
    end
  end

  // Addresses follow idx_n so the owner can register them on the same edge the index moves.
  assign src_addr = (load ? src : src_q) + ADDR_W'(idx_n);
  assign dst_addr = (load ? dst : dst_q) + ADDR_W'(idx_n);
  assign last     = (idx == end_idx);

endmodule

// File: rtl/mem_copy_engine.sv
// Block copy initiator for data_memory: LEN words SRC->DST, overlap safe.
// Optional running checksum of copied words under MEM_COPY_CHECKSUM_EN.
module mem_copy_engine
  import mem_copy_pkg::*;
#(
  parameter int unsigned ADDR_W    = MC_ADDR_W,
  parameter int unsigned DATA_W    = MC_DATA_W,
  parameter int unsigned LEN_W     = MC_LEN_W,
  parameter int unsigned MEM_DEPTH = MC_MEM_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] src,
  input  logic [ADDR_W-1:0] dst,
  input  logic [LEN_W-1:0]  len,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [DATA_W-1:0] checksum,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_rdata
);

  mc_state_t state;

  logic [ADDR_W:0]   src_end;
  logic [ADDR_W:0]   dst_end;
  logic [ADDR_W:0]   depth_lim;
  logic              range_bad;
  logic              desc;
  logic              accept;
  logic              step;
  logic              last;
  logic [ADDR_W-1:0] src_addr;
  logic [ADDR_W-1:0] dst_addr;

  assign depth_lim = (ADDR_W+1)'(MEM_DEPTH);
  assign src_end   = {1'b0, src} + (ADDR_W+1)'(len);
  assign dst_end   = {1'b0, dst} + (ADDR_W+1)'(len);
  assign range_bad = (src_end > depth_lim) || (dst_end > depth_lim);
  // Descending only when dst lands strictly inside the source window.
  assign desc      = (dst > src) && ({1'b0, dst} < src_end);
  assign accept    = (state == ST_IDLE) && start;
  assign step      = (state == ST_WRITE) && !last;

  mem_copy_addr_gen #(
    .ADDR_W(ADDR_W),
    .LEN_W (LEN_W)
  ) u_addr_gen (
    .clk     (clk),
    .rst     (rst),
    .load    (accept),
    .step    (step),
    .desc    (desc),
    .src     (src),
    .dst     (dst),
    .len     (len),
    .src_addr(src_addr),
    .dst_addr(dst_addr),
    .last    (last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            if (range_bad) begin
              state <= ST_DONE;
              done  <= 1'b1;
              err   <= 1'b1;
            end else if (len == '0) begin
              state <= ST_DONE;
              done  <= 1'b1;
            end else begin
              state    <= ST_READ;
              busy     <= 1'b1;
              mem_addr <= src_addr;
              mem_read <= 1'b1;
            end
          end
        end
        ST_READ: begin
          state     <= ST_WRITE;
          mem_wdata <= mem_rdata;
          mem_addr  <= dst_addr;
          mem_read  <= 1'b0;
          mem_write <= 1'b1;
        end
        ST_WRITE: begin
          mem_write <= 1'b0;
          if (last) begin
            state <= ST_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            state    <= ST_READ;
            mem_addr <= src_addr;
            mem_read <= 1'b1;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef MEM_COPY_CHECKSUM_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      checksum <= '0;
    end else if (accept) begin
      checksum <= '0;
    end else if (state == ST_READ) begin
      checksum <= checksum + mem_rdata;
    end
  end
`else
  assign checksum = '0;
`endif

endmodule

// File: tb/tb_mem_copy_engine.sv
// Self-checking bench for mem_copy_engine against a memmove-style reference memory.
module tb_mem_copy_engine;

  localparam int DEPTH = 4000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] src = '0;
  logic [31:0] dst = '0;
  logic [15:0] len = '0;
  logic        busy, done, err, mem_read, mem_write;
  logic [31:0] checksum, mem_addr, mem_wdata, mem_rdata;

  logic        bd_we = 1'b0;
  logic [31:0] bd_addr = '0;
  logic [31:0] bd_data = '0;

  logic [31:0] ram  [0:DEPTH-1];
  logic [31:0] refm [0:DEPTH-1];

  int nrd = 0, nwr = 0, nbad = 0;
  int passed = 0, total = 0;

  always #5 clk = ~clk;

  mem_copy_engine #(
    .ADDR_W   (32),
    .DATA_W   (32),
    .LEN_W    (16),
    .MEM_DEPTH(4000)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .src      (src),
    .dst      (dst),
    .len      (len),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .checksum (checksum),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_read (mem_read),
    .mem_write(mem_write),
    .mem_rdata(mem_rdata)
  );

  assign mem_rdata = (mem_addr < DEPTH) ? ram[mem_addr[11:0]] : '0;

  always @(posedge clk) begin
    if (bd_we) ram[bd_addr[11:0]] <= bd_data;
    else if (mem_write && mem_addr < DEPTH) ram[mem_addr[11:0]] <= mem_wdata;
  end

  always @(posedge clk) begin
    if (!rst) begin
      if (mem_read) nrd++;
      if (mem_write) nwr++;
      if ((mem_read || mem_write) && mem_addr >= DEPTH) nbad++;
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, total=%0d", total);
    $fatal(1);
  end

  // mode 0: random words, mode 1: 10,20,30,...
  task automatic fill(input int a0, input int n, input int mode);
    @(negedge clk);
    for (int k = 0; k < n; k++) begin
      bd_we   = 1'b1;
      bd_addr = a0 + k;
      bd_data = (mode == 1) ? 32'((k + 1) * 10) : $urandom;
      refm[a0 + k] = bd_data;
      @(negedge clk);
    end
    bd_we = 1'b0;
  endtask

  function automatic int mem_diff();
    int n = 0;
    for (int a = 0; a < DEPTH; a++) if (ram[a] !== refm[a]) n++;
    return n;
  endfunction

  // Reference: copy behaves like memmove of the original source words.
  task automatic model_job(input longint s, input longint d, input int l,
                           output logic eerr, output int el, output logic [31:0] esum);
    logic [31:0] tmp[$];
    eerr = (s + l > DEPTH) || (d + l > DEPTH);
    esum = '0;
    if (!eerr && l > 0) begin
      for (int k = 0; k < l; k++) tmp.push_back(refm[int'(s) + k]);
      for (int k = 0; k < l; k++) begin
        refm[int'(d) + k] = tmp[k];
        esum += tmp[k];
      end
    end
`ifndef MEM_COPY_CHECKSUM_EN
    esum = '0;
`endif
    el = (eerr || l == 0) ? 1 : 2 * l + 1;
  endtask

  // Runs one job; poke>0 asserts a bogus start during that cycle.
  task automatic run_job(input longint s, input longint d, input int l, input int poke,
                         output int lat, output logic oerr, output logic [31:0] osum,
                         output int busy_bad, output int post_bad, output int drd, output int dwr);
    int rd0, wr0;
    rd0 = nrd; wr0 = nwr;
    lat = -1; busy_bad = 0; post_bad = 0; oerr = 1'b0; osum = '0;
    @(negedge clk);
    src = 32'(s); dst = 32'(d); len = 16'(l); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 1; c <= 2 * l + 20; c++) begin
      if (c == poke) begin
        start = 1'b1; src = 32'd10; dst = 32'd20; len = 16'd2;
      end
      if (done) begin
        lat = c; oerr = err; osum = checksum;
        if (busy !== 1'b0) busy_bad++;
        break;
      end
      if (busy !== 1'b1) busy_bad++;
      @(posedge clk); #1;
      start = 1'b0;
    end
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (done !== 1'b0 || busy !== 1'b0 || checksum !== osum) post_bad++;
    end
    drd = nrd - rd0; dwr = nwr - wr0;
  endtask

  task automatic test_reset();
    #1;
    total++; if ({busy, done, err, mem_read, mem_write} !== 5'b0) $display("FAIL reset_flags: got %b expected 00000", {busy, done, err, mem_read, mem_write}); else passed++;
    total++; if (mem_addr !== '0 || mem_wdata !== '0) $display("FAIL reset_bus: got addr=%0d wdata=%0d expected 0/0", mem_addr, mem_wdata); else passed++;
    total++; if (checksum !== '0) $display("FAIL reset_checksum: got %0d expected 0", checksum); else passed++;
    fill(0, DEPTH, 0);
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_basic_copy();
    int lat, bb, pb, drd, dwr, el; logic oerr, eerr; logic [31:0] osum, esum;
    fill(1000, 10, 1);
    model_job(1000, 2000, 10, eerr, el, esum);
    run_job(1000, 2000, 10, 0, lat, oerr, osum, bb, pb, drd, dwr);
    total++; if (lat !== 21) $display("FAIL basic_latency: got %0d expected 21", lat); else passed++;
    total++; if (oerr !== 1'b0) $display("FAIL basic_err: got %b expected 0", oerr); else passed++;
`ifdef MEM_COPY_CHECKSUM_EN
    total++; if (osum !== 32'd550) $display("FAIL basic_checksum: got %0d expected 550", osum); else passed++;
`else
    total++; if (osum !== 32'd0) $display("FAIL basic_checksum: got %0d expected 0", osum); else passed++;
`endif
    total++; if (bb !== 0 || pb !== 0) $display("FAIL basic_busy_done: got busy_bad=%0d post_bad=%0d expected 0/0", bb, pb); else passed++;
    total++; if (drd !== 10 || dwr !== 10) $display("FAIL basic_accesses: got rd=%0d wr=%0d expected 10/10", drd, dwr); else passed++;
    total++; if (ram[2000] !== 32'd10 || ram[2009] !== 32'd100) $display("FAIL basic_ends: got %0d,%0d expected 10,100", ram[2000], ram[2009]); else passed++;
    total++; if (mem_diff() !== 0) $display("FAIL basic_memory: got %0d bad words expected 0", mem_diff()); else passed++;
  endtask

  task automatic test_overlap();
    int lat, bb, pb, drd, dwr, el; logic oerr, eerr; logic [31:0] osum, esum;
    model_job(1000, 1002, 5, eerr, el, esum);
    run_job(1000, 1002, 5, 0, lat, oerr, osum, bb, pb, drd, dwr);
    total++; if (lat !== 11 || oerr !== 1'b0) $display("FAIL overlap_done: got lat=%0d err=%b expected 11/0", lat, oerr); else passed++;
    total++; if (ram[1002] !== 32'd10 || ram[1006] !== 32'd50) $display("FAIL overlap_words: got %0d,%0d expected 10,50", ram[1002], ram[1006]); else passed++;
    total++; if (ram[1000] !== 32'd10 || ram[1001] !== 32'd20) $display("FAIL overlap_head: got %0d,%0d expected 10,20", ram[1000], ram[1001]); else passed++;
    total++; if (osum !== esum) $display("FAIL overlap_checksum: got %0d expected %0d", osum, esum); else passed++;
    total++; if (mem_diff() !== 0) $display("FAIL overlap_memory: got %0d bad words expected 0", mem_diff()); else passed++;
  endtask

  task automatic test_len_zero();
    int lat, bb, pb, drd, dwr, el; logic oerr, eerr; logic [31:0] osum, esum;
    model_job(500, 600, 0, eerr, el, esum);
    run_job(500, 600, 0, 0, lat, oerr, osum, bb, pb, drd, dwr);
    total++; if (lat !== 1 || oerr !== 1'b0) $display("FAIL len0_done: got lat=%0d err=%b expected 1/0", lat, oerr); else passed++;
    total++; if (drd !== 0 || dwr !== 0) $display("FAIL len0_accesses: got rd=%0d wr=%0d expected 0/0", drd, dwr); else passed++;
    total++; if (osum !== 32'd0 || bb !== 0 || pb !== 0) $display("FAIL len0_state: got sum=%0d busy_bad=%0d post_bad=%0d expected 0/0/0", osum, bb, pb); else passed++;
  endtask

  task automatic test_range_err();
    int lat, bb, pb, drd, dwr, el; logic oerr, eerr; logic [31:0] osum, esum;
    model_job(3995, 100, 10, eerr, el, esum);
    run_job(3995, 100, 10, 0, lat, oerr, osum, bb, pb, drd, dwr);
    total++; if (lat !== 1 || oerr !== 1'b1) $display("FAIL err_src: got lat=%0d err=%b expected 1/1", lat, oerr); else passed++;
    total++; if (drd !== 0 || dwr !== 0) $display("FAIL err_accesses: got rd=%0d wr=%0d expected 0/0", drd, dwr); else passed++;
    model_job(100, 3991, 10, eerr, el, esum);
    run_job(100, 3991, 10, 0, lat, oerr, osum, bb, pb, drd, dwr);
    total++; if (lat !== 1 || oerr !== 1'b1 || dwr !== 0) $display("FAIL err_dst: got lat=%0d err=%b wr=%0d expected 1/1/0", lat, oerr, dwr); else passed++;
    model_job(3990, 3980, 10, eerr, el, esum);
    run_job(3990, 3980, 10, 0, lat, oerr, osum, bb, pb, drd, dwr);
    total++; if (lat !== 21 || oerr !== 1'b0) $display("FAIL edge_legal: got lat=%0d err=%b expected 21/0", lat, oerr); else passed++;
    total++; if (mem_diff() !== 0 || nbad !== 0) $display("FAIL err_memory: got %0d bad words, %0d illegal accesses expected 0/0", mem_diff(), nbad); else passed++;
  endtask

  task automatic test_start_ignored();
    int lat, bb, pb, drd, dwr, el; logic oerr, eerr; logic [31:0] osum, esum;
    model_job(1000, 2000, 10, eerr, el, esum);
    run_job(1000, 2000, 10, 4, lat, oerr, osum, bb, pb, drd, dwr);
    total++; if (lat !== 21 || bb !== 0) $display("FAIL busy_start_ignored: got lat=%0d busy_bad=%0d expected 21/0", lat, bb); else passed++;
    total++; if (pb !== 0 || drd !== 10 || dwr !== 10) $display("FAIL busy_no_second_job: got post_bad=%0d rd=%0d wr=%0d expected 0/10/10", pb, drd, dwr); else passed++;
    model_job(200, 300, 3, eerr, el, esum);
    run_job(200, 300, 3, 7, lat, oerr, osum, bb, pb, drd, dwr);
    total++; if (lat !== 7 || pb !== 0 || drd !== 3) $display("FAIL done_start_ignored: got lat=%0d post_bad=%0d rd=%0d expected 7/0/3", lat, pb, drd); else passed++;
    total++; if (mem_diff() !== 0) $display("FAIL ignored_memory: got %0d bad words expected 0", mem_diff()); else passed++;
  endtask

  task automatic test_reset_mid();
    int lat, bb, pb, drd, dwr, el, wr0, quiet; logic oerr, eerr; logic [31:0] osum, esum;
    fill(1000, 10, 1);
    fill(2000, 10, 0);
    for (int k = 0; k < 3; k++) refm[2000 + k] = refm[1000 + k];
    wr0 = nwr;
    @(negedge clk);
    src = 32'd1000; dst = 32'd2000; len = 16'd10; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (6) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    total++; if ({busy, done, err, mem_read, mem_write} !== 5'b0 || mem_addr !== '0 || mem_wdata !== '0 || checksum !== '0)
      $display("FAIL midreset_outputs: got flags=%b addr=%0d wdata=%0d sum=%0d expected all 0", {busy, done, err, mem_read, mem_write}, mem_addr, mem_wdata, checksum);
    else passed++;
    @(negedge clk); rst = 1'b0;
    quiet = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (busy || done || mem_read || mem_write) quiet++;
    end
    total++; if (quiet !== 0 || nwr - wr0 !== 3) $display("FAIL midreset_abort: got active=%0d writes=%0d expected 0/3", quiet, nwr - wr0); else passed++;
    total++; if (mem_diff() !== 0) $display("FAIL midreset_memory: got %0d bad words expected 0", mem_diff()); else passed++;
    model_job(1000, 2000, 10, eerr, el, esum);
    run_job(1000, 2000, 10, 0, lat, oerr, osum, bb, pb, drd, dwr);
    total++; if (lat !== 21 || osum !== esum || mem_diff() !== 0) $display("FAIL midreset_restart: got lat=%0d sum=%0d bad=%0d expected 21/%0d/0", lat, osum, mem_diff(), esum); else passed++;
  endtask

  task automatic test_random();
    int lat, bb, pb, drd, dwr, el, l, kind, ewr; longint s, d; logic oerr, eerr; logic [31:0] osum, esum;
    for (int j = 0; j < 16; j++) begin
      kind = $urandom_range(0, 3);
      l = $urandom_range(2, 40);
      case (kind)
        0: begin l = $urandom_range(0, 40); s = $urandom_range(0, 3960); d = $urandom_range(0, 3960); end
        1: begin s = $urandom_range(0, 3900); d = s + $urandom_range(1, l - 1); end
        2: begin s = $urandom_range(100, 3900); d = s - $urandom_range(1, l); end
        default: begin s = DEPTH - l + $urandom_range(0, 1); d = $urandom_range(0, 1000); end
      endcase
      model_job(s, d, l, eerr, el, esum);
      ewr = (eerr || l == 0) ? 0 : l;
      run_job(s, d, l, 0, lat, oerr, osum, bb, pb, drd, dwr);
      total++; if (lat !== el || oerr !== eerr) $display("FAIL rand%0d_done: src=%0d dst=%0d len=%0d got lat=%0d err=%b expected %0d/%b", j, s, d, l, lat, oerr, el, eerr); else passed++;
      total++; if (osum !== esum || drd !== ewr || dwr !== ewr) $display("FAIL rand%0d_sum_acc: got sum=%0d rd=%0d wr=%0d expected %0d/%0d/%0d", j, osum, drd, dwr, esum, ewr, ewr); else passed++;
      total++; if (mem_diff() !== 0 || bb !== 0 || pb !== 0) $display("FAIL rand%0d_mem: got bad=%0d busy_bad=%0d post_bad=%0d expected 0/0/0", j, mem_diff(), bb, pb); else passed++;
    end
    total++; if (nbad !== 0) $display("FAIL illegal_access: got %0d expected 0", nbad); else passed++;
  endtask

  initial begin
    test_reset();
    test_basic_copy();
    test_overlap();
    test_len_zero();
    test_range_err();
    test_start_ignored();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
